// File: rtl/sum_deser_pkg.sv
// sum_deser_pkg: shared state type and default word width for the serial sum deserializer.
package sum_deser_pkg;
    localparam int DEFAULT_WIDTH = 8;
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
endpackage

// File: rtl/sum_deserializer.sv
// sum_deserializer: collects LSB-first serial sum bits into a parallel word with a valid/ready hand-off.
module sum_deserializer
    import sum_deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             sum_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             drop
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             drop_q, drop_d;
    logic             restart, discard;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        restart = 1'b0;
        discard = 1'b0;
        case (state_q)
            IDLE: begin
                restart = start;
                discard = bit_valid && !start;
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    sr_d    = '0;
                end
            end
            SHIFT: begin
                if (start) begin
                    // A restart may carry the first bit of the new word in the same cycle.
                    restart = 1'b1;
                    cnt_d   = bit_valid ? CW'(1) : '0;
                    sr_d    = bit_valid ? {sum_in, {(WIDTH-1){1'b0}}} : '0;
                end else if (bit_valid) begin
                    cnt_d   = cnt_q + CW'(1);
                    sr_d    = {sum_in, sr_q[WIDTH-1:1]};
                    state_d = (cnt_q == LAST) ? HOLD : SHIFT;
                end
            end
            HOLD: begin
                restart = out_ready && start;
                discard = bit_valid && !restart;
                if (out_ready) begin
                    state_d = start ? SHIFT : IDLE;
                    cnt_d   = start ? '0 : cnt_q;
                    sr_d    = start ? '0 : sr_q;
                end
            end
            default: state_d = IDLE;
        endcase
        drop_d = restart ? 1'b0 : (drop_q || discard);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            drop_q  <= 1'b0;
        end else if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            drop_q  <= drop_d;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q == SHIFT);
    assign result    = sr_q;
    assign drop      = drop_q;
endmodule

// File: tb/tb_sum_deserializer.sv
// tb_sum_deserializer: vector table, directed corner sequences and random traffic against a queue-based model.
module tb_sum_deserializer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, clr, start, bit_valid, sum_in, out_ready;
    logic         out_valid, busy, drop;
    logic [W-1:0] result;

    int n_checks = 0;
    int n_errors = 0;

    // Upstream bit-serial adder, registered sum output.
    logic a_clr = 1'b1, a_en = 1'b0, ax = 1'b0, ay = 1'b0, a_c, a_s;
    always_ff @(posedge clk) begin
        if (a_clr) begin
            a_c <= 1'b0;
            a_s <= 1'b0;
        end else if (a_en) begin
            {a_c, a_s} <= 2'(ax) + 2'(ay) + 2'(a_c);
        end
    end

    sum_deserializer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .clr(clr), .start(start), .bit_valid(bit_valid),
        .sum_in(sum_in), .out_ready(out_ready), .out_valid(out_valid),
        .result(result), .busy(busy), .drop(drop)
    );

    always #5 clk = ~clk;

    // Reference model: received bits kept in a queue; word placement by arithmetic.
    logic         m_framing, m_holding, m_drop;
    logic [W-1:0] m_res;
    logic         m_q[$];

    function automatic logic [W-1:0] pack(input int n);
        logic [W-1:0] r = '0;
        for (int i = 0; i < n; i++) r[W - n + i] = m_q[i];
        return r;
    endfunction

    task automatic model_reset();
        m_framing = 1'b0;
        m_holding = 1'b0;
        m_drop    = 1'b0;
        m_res     = '0;
        m_q.delete();
    endtask

    task automatic model_begin();
        m_framing = 1'b1;
        m_q.delete();
        m_res  = '0;
        m_drop = 1'b0;
    endtask

    task automatic model_step();
        if (clr) begin
            model_reset();
        end else if (m_holding) begin
            if (bit_valid && !(out_ready && start)) m_drop = 1'b1;
            if (out_ready) begin
                m_holding = 1'b0;
                if (start) model_begin();
            end
        end else if (m_framing) begin
            if (start) begin
                m_q.delete();
                m_drop = 1'b0;
            end
            if (bit_valid) m_q.push_back(sum_in);
            m_res = pack(m_q.size());
            if (m_q.size() == W) begin
                m_framing = 1'b0;
                m_holding = 1'b1;
            end
        end else if (start) begin
            model_begin();
        end else if (bit_valid) begin
            m_drop = 1'b1;
        end
    endtask

    task automatic check_model(input string name);
        n_checks++;
        if (out_valid !== m_holding || busy !== m_framing || drop !== m_drop || result !== m_res) begin
            n_errors++;
            $display("FAIL %s: got ov=%b busy=%b drop=%b result=%h, want ov=%b busy=%b drop=%b result=%h",
                     name, out_valid, busy, drop, result, m_holding, m_framing, m_drop, m_res);
        end
    endtask

    task automatic check_exp(input string name, input logic [2:0] e, input logic [W-1:0] r);
        n_checks++;
        if ({out_valid, busy, drop} !== e || result !== r) begin
            n_errors++;
            $display("FAIL %s: got ov/busy/drop=%b result=%h, want %b result=%h",
                     name, {out_valid, busy, drop}, result, e, r);
        end
    endtask

    task automatic drive(input logic [3:0] v);
        {start, bit_valid, sum_in, out_ready} = v;
    endtask

    task automatic tick(input string name);
        @(posedge clk);
        if (rst) model_step();
        #1;
        check_model(name);
    endtask

    typedef struct {
        logic [3:0]   in;   // start, bit_valid, sum_in, out_ready
        logic [2:0]   exp;  // out_valid, busy, drop
        logic [W-1:0] res;
    } vec_t;
    vec_t tbl[$];

    logic [W-1:0] pat = 8'hA5;
    logic [W-1:0] ox = 8'h3C, oy = 8'h11;

    initial begin
        rst = 1'b0;
        clr = 1'b0;
        drive(4'b0000);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_exp("reset", 3'b000, 8'h00);
        rst = 1'b1;

        // Basic word, held with discarded bits, accept, then restart mid-word.
        tbl.push_back('{4'b1000, 3'b010, 8'h00});
        tbl.push_back('{4'b0110, 3'b010, 8'h80});
        tbl.push_back('{4'b0100, 3'b010, 8'h40});
        tbl.push_back('{4'b0110, 3'b010, 8'hA0});
        tbl.push_back('{4'b0100, 3'b010, 8'h50});
        tbl.push_back('{4'b0100, 3'b010, 8'h28});
        tbl.push_back('{4'b0110, 3'b010, 8'h94});
        tbl.push_back('{4'b0100, 3'b010, 8'h4A});
        tbl.push_back('{4'b0110, 3'b100, 8'hA5});
        tbl.push_back('{4'b0110, 3'b101, 8'hA5});
        tbl.push_back('{4'b1100, 3'b101, 8'hA5});
        tbl.push_back('{4'b0110, 3'b101, 8'hA5});
        tbl.push_back('{4'b0000, 3'b101, 8'hA5});
        tbl.push_back('{4'b0100, 3'b101, 8'hA5});
        tbl.push_back('{4'b0001, 3'b001, 8'hA5});
        tbl.push_back('{4'b1000, 3'b010, 8'h00});
        tbl.push_back('{4'b0110, 3'b010, 8'h80});
        tbl.push_back('{4'b0110, 3'b010, 8'hC0});
        tbl.push_back('{4'b0110, 3'b010, 8'hE0});
        tbl.push_back('{4'b1110, 3'b010, 8'h80});
        tbl.push_back('{4'b0110, 3'b010, 8'hC0});
        tbl.push_back('{4'b0110, 3'b010, 8'hE0});
        tbl.push_back('{4'b0110, 3'b010, 8'hF0});
        tbl.push_back('{4'b0110, 3'b010, 8'hF8});
        tbl.push_back('{4'b0110, 3'b010, 8'hFC});
        tbl.push_back('{4'b0110, 3'b010, 8'hFE});
        tbl.push_back('{4'b0110, 3'b100, 8'hFF});
        tbl.push_back('{4'b0001, 3'b000, 8'hFF});
        foreach (tbl[i]) begin
            drive(tbl[i].in);
            tick("vec_model");
            check_exp($sformatf("vec%0d", i), tbl[i].exp, tbl[i].res);
        end

        // Gapped word: valid every other cycle.
        drive(4'b1000);
        tick("gap_start");
        for (int c = 0; c < 16; c++) begin
            drive({1'b0, (c % 2) == 0, pat[c / 2], 1'b0});
            tick("gap_model");
            if (c < 14) check_exp("gap_busy", 3'b010, m_res);
        end
        check_exp("gap_done", 3'b100, 8'hA5);
        drive(4'b0001);
        tick("gap_accept");

        // Asynchronous reset mid-word, then a fresh word.
        drive(4'b1000);
        tick("ar_start");
        for (int i = 0; i < 4; i++) begin
            drive({2'b01, pat[i], 1'b0});
            tick("ar_bits");
        end
        #3 rst = 1'b0;
        model_reset();
        #1 check_exp("async_rst", 3'b000, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        drive(4'b1000);
        tick("ar_restart");
        for (int i = 0; i < W; i++) begin
            drive({2'b01, pat[i], 1'b0});
            tick("ar_word");
        end
        check_exp("ar_fresh", 3'b100, 8'hA5);
        drive(4'b0001);
        tick("ar_accept");

        // clr wins over a simultaneous start.
        drive(4'b1000);
        tick("clr_start");
        drive(4'b0110);
        tick("clr_bit");
        clr = 1'b1;
        drive(4'b1110);
        tick("clr_model");
        check_exp("clr_prio", 3'b000, 8'h00);
        clr = 1'b0;

        // Bit-serial adder upstream, its sum arriving one cycle later.
        drive(4'b0000);
        tick("add_idle");
        a_clr = 1'b0;
        drive(4'b1000);
        a_en = 1'b1;
        ax = ox[0];
        ay = oy[0];
        tick("add_start");
        for (int i = 1; i <= W; i++) begin
            drive({2'b01, a_s, 1'b0});
            a_en = (i < W);
            ax = (i < W) ? ox[i % W] : 1'b0;
            ay = (i < W) ? oy[i % W] : 1'b0;
            tick("add_bits");
        end
        check_exp("adder_sum", 3'b100, 8'h4D);
        drive(4'b0001);
        tick("add_accept");

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            clr = ($urandom_range(0, 49) == 0);
            drive({$urandom_range(0, 7) == 0, 1'($urandom), 1'($urandom), $urandom_range(0, 4) < 2});
            tick("random");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
